// File: rtl/quadrilatero_sa_skew.sv
// Operand skew buffer feeding the left edge of the systolic array.
// Lane r is delayed by r pumps; drain flushes zeros with the last control.
package quadrilatero_pkg;

    typedef struct packed {
        logic [1:0] datatype;
        logic       is_float;
    } sa_ctrl_t;

endpackage

module quadrilatero_sa_skew
    import quadrilatero_pkg::*;
#(
    parameter int N_ROWS     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [N_ROWS*DATA_WIDTH-1:0] data_i,
    input  logic                         last_i,
    input  sa_ctrl_t                     sa_ctrl_i,
    input  logic                         stall_i,
    output logic                         pump_o,
    output logic [N_ROWS*DATA_WIDTH-1:0] data_o,
    output sa_ctrl_t                     sa_ctrl_o [N_ROWS],
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int CW = $clog2(N_ROWS + 1);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   done_q;
    sa_ctrl_t               last_ctrl_q;

    logic                   accept;
    logic                   in_drain;
    logic [N_ROWS*DW-1:0]   lane_in;
    sa_ctrl_t               ctrl_in;

    assign in_drain = (state_q == DRAIN);
    assign ready_o  = !stall_i && !in_drain;
    assign accept   = valid_i && ready_o;
    assign pump_o   = accept || (in_drain && !stall_i);
    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;

    // Drain pumps inject zeros but keep the operand's datatype in every row
    assign lane_in  = in_drain ? '0 : data_i;
    assign ctrl_in  = in_drain ? last_ctrl_q : sa_ctrl_i;

    assign data_o[0 +: DW] = lane_in[0 +: DW];
    assign sa_ctrl_o[0]    = ctrl_in;

    // Operand sequencing: stream columns, then flush the skew with drain pumps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            last_ctrl_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                last_ctrl_q <= sa_ctrl_i;
            end
            unique case (state_q)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (!last_i) begin
                            state_q <= STREAM;
                        end else if (N_ROWS == 1) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                            cnt_q   <= CW'(N_ROWS - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (!stall_i) begin
                        if (cnt_q == CW'(1)) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar r = 1; r < N_ROWS; r++) begin : g_lane
        logic [DW-1:0] d_q [r];
        sa_ctrl_t      c_q [r];

        // Lane delay line of r stages, advancing only on a pump
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int j = 0; j < r; j++) begin
                    d_q[j] <= '0;
                    c_q[j] <= '0;
                end
            end else if (pump_o) begin
                d_q[0] <= lane_in[r*DW +: DW];
                c_q[0] <= ctrl_in;
                for (int j = 1; j < r; j++) begin
                    d_q[j] <= d_q[j-1];
                    c_q[j] <= c_q[j-1];
                end
            end
        end

        assign data_o[r*DW +: DW] = d_q[r-1];
        assign sa_ctrl_o[r]       = c_q[r-1];
    end

endmodule
